// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
//   Definitions shared by the layer read driver and the RAM write driver:
//   layer geometry, data widths, write-back FSM state encodings and the
//   layer -> RAM region base address helpers.
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int NUM_UNITS    = 4;   // neuron units per layer
  localparam int ACC_W        = 16;  // signed accumulator width of a unit
  localparam int DATA_W       = 8;   // signed RAM word width
  localparam int ADDR_W       = 10;  // RAM address width
  localparam int LAYER_STRIDE = 4;   // RAM words per layer region
  localparam int FRAC_SHIFT   = 4;   // fixed-point rescale before narrowing
  localparam int SEL_W        = 2;   // unit select width
  localparam int LAYER_W      = 2;   // layer index width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_CAPT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } drv_state_e;

  // Base address of a layer's RAM region; the 2-bit layer zero-extends.
  function automatic logic [ADDR_W-1:0] layer_base(input logic [LAYER_W-1:0] layer_i);
    return ADDR_W'(layer_i) * ADDR_W'(LAYER_STRIDE);
  endfunction

  // Region of the layer that consumes the results of layer_i.
  function automatic logic [ADDR_W-1:0] next_layer_base(input logic [LAYER_W-1:0] layer_i);
    return layer_base(layer_i) + ADDR_W'(LAYER_STRIDE);
  endfunction

endpackage

// File: rtl/result_scaler.sv
// -----------------------------------------------------------------------------
// result_scaler
//   Combinational rescale of a unit's accumulated result to a RAM word:
//   arithmetic right shift by FRAC_SHIFT, then narrowing to DATA_W.
//   Build option WRITE_SAT_EN: when defined, the shifted value is clamped to
//   the signed DATA_W range before narrowing; otherwise it is truncated.
// Ports
//   acc_i   in  ACC_W   signed accumulated result
//   data_o  out DATA_W  scaled RAM word
// -----------------------------------------------------------------------------
module result_scaler
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic        [DATA_W-1:0] data_o
);

`ifdef WRITE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc_i >>> FRAC_SHIFT;

  // Clamp out-of-range values so overflow saturates rather than wrapping.
  always_comb begin
    data_o = shifted_s[DATA_W-1:0];
    if (shifted_s > SAT_MAX) begin
      data_o = SAT_MAX[DATA_W-1:0];
    end else if (shifted_s < SAT_MIN) begin
      data_o = SAT_MIN[DATA_W-1:0];
    end else begin
      data_o = shifted_s[DATA_W-1:0];
    end
  end
`else
  // Keep only the low DATA_W bits of the sign-preserving shift.
  assign data_o = DATA_W'(acc_i >>> FRAC_SHIFT);
`endif

endmodule

// File: rtl/ram_write_driver.sv
// -----------------------------------------------------------------------------
// ram_write_driver
//   Write-back driver run after a layer's summation. Walks every neuron unit,
//   selects its result, rescales it (result_scaler) and writes it into the
//   next layer's RAM region, one word per unit, then pulses done.
//   Build option WRITE_SAT_EN selects saturating instead of truncating
//   narrowing inside result_scaler; timing is identical in both builds.
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begin a pass (honoured only when idle)
//   layer        in   layer just computed, sampled on an accepted start
//   unit_result  in   result of the selected unit (one cycle after unit_sel)
//   unit_sel     out  unit result select
//   RAM_address  out  RAM write address
//   RAM_wdata    out  RAM write data
//   RAM_we       out  RAM write strobe, one cycle per word
//   busy         out  high from accepted start through the done cycle
//   done         out  one-cycle end-of-pass pulse
//   layer_err    out  one-cycle pulse: start accepted with layer 3
// -----------------------------------------------------------------------------
module ram_write_driver
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         layer,
  input  logic [ACC_W-1:0]   unit_result,
  output logic [1:0]         unit_sel,
  output logic [ADDR_W-1:0]  RAM_address,
  output logic [DATA_W-1:0]  RAM_wdata,
  output logic               RAM_we,
  output logic               busy,
  output logic               done,
  output logic               layer_err
);

  // Addresses of one pass must stay inside the destination region.
  if (NUM_UNITS > LAYER_STRIDE) begin : g_units_exceed_stride
    $error("NUM_UNITS must not exceed LAYER_STRIDE");
  end

  localparam logic [1:0] LAST_UNIT = 2'(NUM_UNITS - 1);

  drv_state_e          state_q,  state_d;
  logic [1:0]          sel_q,    sel_d;    // unit select doubles as unit counter
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic                we_q,     we_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;
  logic [DATA_W-1:0]   scaled_s;

  result_scaler u_scaler (
    .acc_i  (unit_result),
    .data_o (scaled_s)
  );

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (layer == 2'd3) begin
            // No region follows the last layer: flag it and finish at once.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            sel_d   = 2'd0;
            addr_d  = next_layer_base(layer);
            busy_d  = 1'b1;
            state_d = ST_SEL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // unit_sel is already presented; give the unit its register cycle.
      ST_SEL: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        wdata_d = scaled_s;
        we_d    = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (sel_q == LAST_UNIT) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          sel_d   = sel_q + 2'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_SEL;
        end
      end
      // Select and address are held; busy drops as we leave.
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign unit_sel    = sel_q;
  assign RAM_address = addr_q;
  assign RAM_wdata   = wdata_q;
  assign RAM_we      = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign layer_err   = err_q;

endmodule

// File: tb/tb_ram_write_driver.sv
// -----------------------------------------------------------------------------
// tb_ram_write_driver
//   Directed bench for ram_write_driver. A cycle-indexed model of a pass
//   (cycle n after the accepting edge: write every third cycle, done at
//   3*NUM_UNITS+1) is compared against the DUT on every falling edge, and
//   literal expectations pin each directed scenario. Honours WRITE_SAT_EN.
// -----------------------------------------------------------------------------
module tb_ram_write_driver;
  import nn_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        layer;
  logic [ACC_W-1:0]  unit_result = '0;
  logic [1:0]        unit_sel;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_wdata;
  logic              RAM_we;
  logic              busy;
  logic              done;
  logic              layer_err;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] res_tbl [NUM_UNITS];

  always #5 clk = ~clk;

  ram_write_driver dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .layer       (layer),
    .unit_result (unit_result),
    .unit_sel    (unit_sel),
    .RAM_address (RAM_address),
    .RAM_wdata   (RAM_wdata),
    .RAM_we      (RAM_we),
    .busy        (busy),
    .done        (done),
    .layer_err   (layer_err)
  );

  // Neuron units: registered result, one cycle behind unit_sel.
  always @(posedge clk) unit_result <= res_tbl[unit_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result -> RAM word from plain integer arithmetic: floor(r/2^FRAC_SHIFT).
  function automatic logic [DATA_W-1:0] ref_scale(input logic [ACC_W-1:0] r);
    int v, s, d;
    d = 2 ** FRAC_SHIFT;
    v = int'($signed(r));
    s = (v - (((v % d) + d) % d)) / d;
`ifdef WRITE_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return DATA_W'(((s % 256) + 256) % 256);
  endfunction

  // Pass model: m_c is the cycle number within the pass (0 = idle).
  int                m_c = 0;
  logic              m_err = 1'b0;
  logic [ADDR_W-1:0] m_base = '0;
  int                since_acc = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_c   = 0;
      m_err = 1'b0;
    end else begin
      logic acc;
      acc   = start && (m_c == 0);
      m_err = 1'b0;
      if (m_c != 0) m_c = (m_c >= 3 * NUM_UNITS + 1) ? 0 : m_c + 1;
      if (acc) begin
        since_acc = 0;
        if (layer == 2'd3) m_err = 1'b1;
        else begin
          m_c    = 1;
          m_base = ADDR_W'((int'(layer) + 1) * LAYER_STRIDE);
        end
      end
    end
  end

  // Observations used by the directed literal checks.
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int                wr_cyc_q  [$];
  int n_done = 0, n_busy = 0, n_err = 0, done_at = 0;

  // Per-cycle comparison against the model, plus observation capture.
  always @(negedge clk) begin
    logic exp_we;
    int j;
    since_acc++;
    exp_we = (m_c > 0) && (m_c % 3 == 0) && (m_c <= 3 * NUM_UNITS);
    check("RAM_we",    {31'd0, RAM_we},    {31'd0, exp_we});
    check("busy",      {31'd0, busy},      {31'd0, (m_c > 0)});
    check("done",      {31'd0, done},      {31'd0, (m_c == 3 * NUM_UNITS + 1) || m_err});
    check("layer_err", {31'd0, layer_err}, {31'd0, m_err});
    if (exp_we && RAM_we) begin
      j = m_c / 3 - 1;
      check("RAM_address", 32'(RAM_address), 32'(m_base + ADDR_W'(j)));
      check("RAM_wdata",   32'(RAM_wdata),   32'(ref_scale(res_tbl[j])));
    end
    if (RAM_we) begin
      wr_addr_q.push_back(RAM_address);
      wr_data_q.push_back(RAM_wdata);
      wr_cyc_q.push_back(since_acc);
    end
    if (done && n_done == 0) done_at = since_acc;
    if (done) n_done++;
    if (busy) n_busy++;
    if (layer_err) n_err++;
  end

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    n_done = 0; n_busy = 0; n_err = 0; done_at = 0;
  endtask

  task automatic pulse_start(input logic [1:0] l);
    @(negedge clk); start = 1'b1; layer = l;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare captured writes with literal addresses/data.
  task automatic check_writes(input string tag, input logic [ADDR_W-1:0] base,
                              input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                              input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    logic [DATA_W-1:0] exp_d [4];
    exp_d = '{d0, d1, d2, d3};
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(base + ADDR_W'(i)));
      check({tag, "_data"}, 32'(wr_data_q[i]), 32'(exp_d[i]));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; layer = 2'd0;
    res_tbl = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    wait_cycles(3);
    check("rst_unit_sel", 32'(unit_sel), 32'd0);
    check("rst_address",  32'(RAM_address), 32'd0);
    check("rst_wdata",    32'(RAM_wdata), 32'd0);
    reset = 1'b1;
    wait_cycles(2);

    // 1: layer 0, ascending results
    res_tbl = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    clear_obs();
    pulse_start(2'd0);
    wait_cycles(16);
    check_writes("t1", 10'd4, 8'h01, 8'h02, 8'h03, 8'h04);
    if (wr_cyc_q.size() == 4) begin
      check("t1_we_cyc0", 32'(wr_cyc_q[0]), 32'd3);
      check("t1_we_cyc1", 32'(wr_cyc_q[1]), 32'd6);
      check("t1_we_cyc3", 32'(wr_cyc_q[3]), 32'd12);
    end else begin
      check("t1_we_count", 32'(wr_cyc_q.size()), 32'd4);
    end
    check("t1_done_cycle", 32'(done_at), 32'd13);
    check("t1_ndone", 32'(n_done), 32'd1);

    // 2: layer 2, negative results
    res_tbl = '{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0};
    clear_obs();
    pulse_start(2'd2);
    wait_cycles(16);
    check_writes("t2", 10'd12, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("t2_busy_cycles", 32'(n_busy), 32'd13);

    // 3: overflow in both directions
    res_tbl = '{16'h7FF0, 16'h8000, 16'h7FF0, 16'h8000};
    clear_obs();
    pulse_start(2'd0);
    wait_cycles(16);
`ifdef WRITE_SAT_EN
    check_writes("t3", 10'd4, 8'h7F, 8'h80, 8'h7F, 8'h80);
`else
    check_writes("t3", 10'd4, 8'hFF, 8'h00, 8'hFF, 8'h00);
`endif

    // 4: layer 3 is rejected
    clear_obs();
    pulse_start(2'd3);
    wait_cycles(6);
    check("t4_nerr", 32'(n_err), 32'd1);
    check("t4_ndone", 32'(n_done), 32'd1);
    check("t4_done_cycle", 32'(done_at), 32'd1);
    check("t4_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check("t4_busy_cycles", 32'(n_busy), 32'd0);

    // 5: restarts during unit 1's write and during the done cycle are ignored
    res_tbl = '{16'h0050, 16'h0060, 16'h0070, 16'h0080};
    clear_obs();
    pulse_start(2'd0);        // returns in cycle 1
    wait_cycles(4);           // now in cycle 5; start is sampled at the end of cycle 6
    pulse_start(2'd2);
    wait_cycles(5);           // now in cycle 12; start is sampled at the end of cycle 13
    pulse_start(2'd1);
    wait_cycles(6);
    check_writes("t5", 10'd4, 8'h05, 8'h06, 8'h07, 8'h08);
    check("t5_ndone", 32'(n_done), 32'd1);

    // 6: asynchronous reset after the second write, then a fresh pass
    res_tbl = '{16'h0110, 16'h0120, 16'h0130, 16'h0140};
    clear_obs();
    pulse_start(2'd0);        // cycle 1
    wait_cycles(6);           // cycle 7: two writes done
    check("t6_pre_nwrites", 32'(wr_addr_q.size()), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_unit_sel", 32'(unit_sel), 32'd0);
    check("t6_rst_address",  32'(RAM_address), 32'd0);
    check("t6_rst_wdata",    32'(RAM_wdata), 32'd0);
    check("t6_rst_flags",    {28'd0, RAM_we, busy, done, layer_err}, 32'd0);
    wait_cycles(3);
    #2 reset = 1'b1;
    clear_obs();
    wait_cycles(3);
    check("t6_idle_nwrites", 32'(wr_addr_q.size()), 32'd0);
    res_tbl = '{16'h0010, 16'hFFE0, 16'h0100, 16'h07F0};
    pulse_start(2'd1);
    wait_cycles(16);
`ifdef WRITE_SAT_EN
    check_writes("t6", 10'd8, 8'h01, 8'hFE, 8'h10, 8'h7F);
`else
    check_writes("t6", 10'd8, 8'h01, 8'hFE, 8'h10, 8'h7F);
`endif
    check("t6_ndone", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
